// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI burst controller sequencing chip-select timing, per-word TX handshakes and RX strobes.
module spi_xfer_ctrl #(
  parameter int SPI_DATA_WIDTH  = 8,
  parameter int CS_DEVICE_COUNT = 1,
  parameter int MAX_WORDS       = 16,
  parameter int CS_SETUP_CYCLES = 4,
  parameter int CS_HOLD_CYCLES  = 4,
  parameter int CS_IDLE_CYCLES  = 8,
  localparam int CS_SEL_W = (CS_DEVICE_COUNT > 1) ? $clog2(CS_DEVICE_COUNT) : 1,
  localparam int LEN_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic                       clkIn,
  input  logic                       rstIn,
  input  logic                       cmdValidIn,
  output logic                       cmdReadyOut,
  input  logic [CS_SEL_W-1:0]        cmdCsSelIn,
  input  logic [LEN_W-1:0]           cmdLenIn,
  input  logic                       txValidIn,
  output logic                       txReadyOut,
  input  logic [SPI_DATA_WIDTH-1:0]  txDataIn,
  output logic                       spiEnOut,
  output logic                       spiLoadOut,
  output logic [SPI_DATA_WIDTH-1:0]  spiTxDataOut,
  input  logic                       spiWordDoneIn,
  input  logic [SPI_DATA_WIDTH-1:0]  spiRxDataIn,
  output logic                       rxValidOut,
  output logic [SPI_DATA_WIDTH-1:0]  rxDataOut,
  output logic [CS_DEVICE_COUNT-1:0] spiCsLowOut,
  output logic                       busyOut,
  output logic                       errOut
);
  localparam int CNT_MAX = (CS_IDLE_CYCLES > CS_SETUP_CYCLES) ?
                           ((CS_IDLE_CYCLES > CS_HOLD_CYCLES) ? CS_IDLE_CYCLES : CS_HOLD_CYCLES) :
                           ((CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  if (CS_SETUP_CYCLES < 1 || CS_HOLD_CYCLES < 1 || CS_IDLE_CYCLES < 1) begin : g_bad_cycles
    $error("spi_xfer_ctrl: CS_*_CYCLES must be at least 1");
  end
  typedef enum logic [2:0] {IDLE, SETUP, WAIT_TX, SHIFT, HOLD, GAP} state_t;
  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [LEN_W-1:0]            rem_q, rem_d;
  logic [CS_SEL_W-1:0]         sel_q, sel_d;
  logic [SPI_DATA_WIDTH-1:0]   tx_data_q, tx_data_d, rx_data_q, rx_data_d;
  logic                        load_q, load_d, rx_valid_q, rx_valid_d, err_q, err_d;
  logic                        cmd_ready_q, cmd_ready_d, tx_ready_q, tx_ready_d;
  logic                        spi_en_q, spi_en_d, busy_q, busy_d;
  logic [CS_DEVICE_COUNT-1:0]  cs_low_q, cs_low_d;
  logic                        cmd_bad;
  assign cmd_bad = (cmdLenIn == '0) || (cmdLenIn > LEN_W'(MAX_WORDS)) ||
                   ({1'b0, cmdCsSelIn} >= (CS_SEL_W + 1)'(CS_DEVICE_COUNT));
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    sel_d      = sel_q;
    tx_data_d  = tx_data_q;
    rx_data_d  = rx_data_q;
    load_d     = 1'b0;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (cmdValidIn) begin
        err_d = cmd_bad;
        if (!cmd_bad) begin
          state_d = SETUP;
          sel_d   = cmdCsSelIn;
          rem_d   = cmdLenIn;
          cnt_d   = CNT_W'(CS_SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        state_d = (cnt_q == '0) ? WAIT_TX : SETUP;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
      end
      WAIT_TX: if (txValidIn) begin
        state_d   = SHIFT;
        tx_data_d = txDataIn;
        load_d    = 1'b1;
      end
      SHIFT: if (spiWordDoneIn) begin
        rx_data_d  = spiRxDataIn;
        rx_valid_d = 1'b1;
        rem_d      = rem_q - LEN_W'(1);
        state_d    = (rem_q == LEN_W'(1)) ? HOLD : WAIT_TX;
        cnt_d      = CNT_W'(CS_HOLD_CYCLES - 1);
      end
      HOLD: begin
        state_d = (cnt_q == '0) ? GAP : HOLD;
        cnt_d   = (cnt_q == '0) ? CNT_W'(CS_IDLE_CYCLES - 1) : cnt_q - CNT_W'(1);
      end
      GAP: begin
        state_d = (cnt_q == '0) ? IDLE : GAP;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered decodes of the next state so they line up with it.
    cmd_ready_d = (state_d == IDLE);
    tx_ready_d  = (state_d == WAIT_TX);
    spi_en_d    = (state_d == SHIFT);
    busy_d      = (state_d != IDLE);
    cs_low_d    = (state_d inside {SETUP, WAIT_TX, SHIFT, HOLD}) ?
                  ~(CS_DEVICE_COUNT'(1) << sel_d) : '1;
  end
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      sel_q       <= '0;
      tx_data_q   <= '0;
      rx_data_q   <= '0;
      load_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      tx_ready_q  <= 1'b0;
      spi_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      cs_low_q    <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      sel_q       <= sel_d;
      tx_data_q   <= tx_data_d;
      rx_data_q   <= rx_data_d;
      load_q      <= load_d;
      rx_valid_q  <= rx_valid_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      tx_ready_q  <= tx_ready_d;
      spi_en_q    <= spi_en_d;
      busy_q      <= busy_d;
      cs_low_q    <= cs_low_d;
    end
  end
  assign cmdReadyOut  = cmd_ready_q;
  assign txReadyOut   = tx_ready_q;
  assign spiEnOut     = spi_en_q;
  assign spiLoadOut   = load_q;
  assign spiTxDataOut = tx_data_q;
  assign rxValidOut   = rx_valid_q;
  assign rxDataOut    = rx_data_q;
  assign spiCsLowOut  = cs_low_q;
  assign busyOut      = busy_q;
  assign errOut       = err_q;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed self-checking bench for spi_xfer_ctrl (3 chip selects, 4/4/8 CS timing).
module tb_spi_xfer_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_sel = '0;
  logic [4:0] cmd_len = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = '0;
  logic       spi_en, spi_load;
  logic [7:0] spi_tx;
  logic       word_done = 1'b0;
  logic [7:0] spi_rx = '0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [2:0] cs_low;
  logic       busy, err;

  int n_cmp = 0, n_bad = 0;
  int n_load = 0, n_rxv = 0, n_multi_cs = 0;
  logic       obs_load, obs_en, obs_rxv, obs_en_after;
  logic [7:0] obs_tx, obs_rx;
  logic [2:0] obs_cs;

  spi_xfer_ctrl #(
    .SPI_DATA_WIDTH(8), .CS_DEVICE_COUNT(3), .MAX_WORDS(16),
    .CS_SETUP_CYCLES(4), .CS_HOLD_CYCLES(4), .CS_IDLE_CYCLES(8)
  ) dut (
    .clkIn(clk), .rstIn(rst),
    .cmdValidIn(cmd_valid), .cmdReadyOut(cmd_ready), .cmdCsSelIn(cmd_sel), .cmdLenIn(cmd_len),
    .txValidIn(tx_valid), .txReadyOut(tx_ready), .txDataIn(tx_data),
    .spiEnOut(spi_en), .spiLoadOut(spi_load), .spiTxDataOut(spi_tx),
    .spiWordDoneIn(word_done), .spiRxDataIn(spi_rx),
    .rxValidOut(rx_valid), .rxDataOut(rx_data),
    .spiCsLowOut(cs_low), .busyOut(busy), .errOut(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spi_load === 1'b1) n_load++;
    if (rx_valid === 1'b1) n_rxv++;
    if ($countones(~cs_low) > 1) n_multi_cs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [1:0] sel, input logic [4:0] len);
    cmd_valid = 1'b1; cmd_sel = sel; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    if (cmd_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_wait: cmdReadyOut=%b required 1", cmd_ready);
    end
  endtask

  // Handshakes one word, then plays the shifter: word done 16 cycles after the load pulse.
  task automatic do_word(input logic [7:0] tx, input logic [7:0] rx, input int delay);
    int k = 0;
    while (tx_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    if (tx_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL tx_ready_wait: txReadyOut=%b required 1", tx_ready);
    end
    repeat (delay) @(negedge clk);
    tx_valid = 1'b1; tx_data = tx;
    @(negedge clk);
    tx_valid = 1'b0;
    obs_load = spi_load; obs_en = spi_en; obs_tx = spi_tx;
    repeat (15) @(negedge clk);
    word_done = 1'b1; spi_rx = rx;
    @(negedge clk);
    word_done = 1'b0;
    obs_rxv = rx_valid; obs_rx = rx_data; obs_en_after = spi_en; obs_cs = cs_low;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_len = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (cs_low !== 3'b111 || err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: cs=%b err=%b busy=%b rdy=%b required cs=111 err=0 busy=0 rdy=1",
                 i, cs_low, err, busy, cmd_ready);
      end
    end
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || tx_ready !== 1'b0 || spi_en !== 1'b0 || spi_load !== 1'b0 ||
        rx_valid !== 1'b0 || spi_tx !== 8'h00 || rx_data !== 8'h00 || cs_low !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%b txr=%b en=%b ld=%b rxv=%b tx=%h rx=%h cs=%b required 1 0 0 0 0 00 00 111",
               cmd_ready, tx_ready, spi_en, spi_load, rx_valid, spi_tx, rx_data, cs_low);
    end
  endtask

  task automatic test_single_word();
    int ld0 = n_load, rx0 = n_rxv;
    send_cmd(2'd1, 5'd1);
    n_cmp++;
    if (cs_low !== 3'b101 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL single_accept: cs=%b busy=%b rdy=%b required cs=101 busy=1 rdy=0", cs_low, busy, cmd_ready);
    end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (tx_ready !== 1'b0 || cs_low !== 3'b101) begin
        n_bad++;
        $display("FAIL single_setup[t+%0d]: txr=%b cs=%b required txr=0 cs=101", i, tx_ready, cs_low);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (tx_ready !== 1'b1 || spi_en !== 1'b0) begin
      n_bad++;
      $display("FAIL single_tx_ready_t5: txr=%b en=%b required txr=1 en=0", tx_ready, spi_en);
    end
    do_word(8'hA5, 8'h3C, 0);
    n_cmp++;
    if (obs_load !== 1'b1 || obs_tx !== 8'hA5 || obs_en !== 1'b1) begin
      n_bad++;
      $display("FAIL single_load: ld=%b tx=%h en=%b required ld=1 tx=a5 en=1", obs_load, obs_tx, obs_en);
    end
    n_cmp++;
    if (obs_rxv !== 1'b1 || obs_rx !== 8'h3C || obs_en_after !== 1'b0 || obs_cs !== 3'b101) begin
      n_bad++;
      $display("FAIL single_rx: rxv=%b rx=%h en=%b cs=%b required rxv=1 rx=3c en=0 cs=101",
               obs_rxv, obs_rx, obs_en_after, obs_cs);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (cs_low !== 3'b101 || rx_valid !== 1'b0 || tx_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL single_hold[%0d]: cs=%b rxv=%b txr=%b required cs=101 rxv=0 txr=0", i, cs_low, rx_valid, tx_ready);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (cs_low !== 3'b111 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL single_gap_start: cs=%b busy=%b rdy=%b required cs=111 busy=1 rdy=0", cs_low, busy, cmd_ready);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b0 || cs_low !== 3'b111) begin
        n_bad++;
        $display("FAIL single_gap[%0d]: rdy=%b cs=%b required rdy=0 cs=111", i, cmd_ready, cs_low);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle: rdy=%b busy=%b required rdy=1 busy=0", cmd_ready, busy);
    end
    n_cmp++;
    if (n_load - ld0 != 1 || n_rxv - rx0 != 1) begin
      n_bad++;
      $display("FAIL single_pulse_count: loads=%0d rx=%0d required 1 1", n_load - ld0, n_rxv - rx0);
    end
  endtask

  task automatic test_multi_word();
    logic [7:0] txw [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] rxw [3] = '{8'hC1, 8'hC2, 8'hC3};
    int ld0 = n_load, rx0 = n_rxv;
    send_cmd(2'd2, 5'd3);
    for (int w = 0; w < 3; w++) begin
      do_word(txw[w], rxw[w], 5);
      n_cmp++;
      if (obs_load !== 1'b1 || obs_tx !== txw[w] || obs_rxv !== 1'b1 || obs_rx !== rxw[w] ||
          obs_en_after !== 1'b0 || obs_cs !== 3'b011) begin
        n_bad++;
        $display("FAIL multi_word[%0d]: ld=%b tx=%h rxv=%b rx=%h en=%b cs=%b required 1 %h 1 %h 0 011",
                 w, obs_load, obs_tx, obs_rxv, obs_rx, obs_en_after, obs_cs, txw[w], rxw[w]);
      end
      if (w < 2) begin
        n_cmp++;
        if (tx_ready !== 1'b1 || spi_en !== 1'b0) begin
          n_bad++;
          $display("FAIL multi_between[%0d]: txr=%b en=%b required txr=1 en=0", w, tx_ready, spi_en);
        end
      end
    end
    wait_idle();
    n_cmp++;
    if (n_load - ld0 != 3 || n_rxv - rx0 != 3) begin
      n_bad++;
      $display("FAIL multi_pulse_count: loads=%0d rx=%0d required 3 3", n_load - ld0, n_rxv - rx0);
    end
  endtask

  task automatic test_reject();
    logic [1:0] sels [3] = '{2'd0, 2'd3, 2'd0};
    logic [4:0] lens [3] = '{5'd0, 5'd1, 5'd17};
    for (int i = 0; i < 3; i++) begin
      send_cmd(sels[i], lens[i]);
      n_cmp++;
      if (err !== 1'b1 || cs_low !== 3'b111 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reject[%0d]_err: err=%b cs=%b busy=%b rdy=%b required 1 111 0 1", i, err, cs_low, busy, cmd_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b0 || cs_low !== 3'b111 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reject[%0d]_after: err=%b cs=%b busy=%b required 0 111 0", i, err, cs_low, busy);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int rx0;
    send_cmd(2'd0, 5'd3);
    do_word(8'h01, 8'hE1, 0);
    while (tx_ready !== 1'b1) @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h02;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    rx0 = n_rxv;
    rst = 1'b1; word_done = 1'b1; spi_rx = 8'hEE;
    @(negedge clk);
    rst = 1'b0; word_done = 1'b0;
    n_cmp++;
    if (cs_low !== 3'b111 || cmd_ready !== 1'b1 || busy !== 1'b0 || spi_en !== 1'b0 || rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset: cs=%b rdy=%b busy=%b en=%b rxv=%b required 111 1 0 0 0",
               cs_low, cmd_ready, busy, spi_en, rx_valid);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_rxv != rx0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_quiet: rx_strobes=%0d rdy=%b required 0 1", n_rxv - rx0, cmd_ready);
    end
    send_cmd(2'd2, 5'd1);
    do_word(8'h5A, 8'hC3, 1);
    n_cmp++;
    if (obs_tx !== 8'h5A || obs_rxv !== 1'b1 || obs_rx !== 8'hC3 || obs_cs !== 3'b011) begin
      n_bad++;
      $display("FAIL midreset_fresh: tx=%h rxv=%b rx=%h cs=%b required 5a 1 c3 011", obs_tx, obs_rxv, obs_rx, obs_cs);
    end
    wait_idle();
  endtask

  task automatic test_stray_done();
    int rx0 = n_rxv;
    word_done = 1'b1; spi_rx = 8'h99;
    @(negedge clk);
    word_done = 1'b0;
    n_cmp++;
    if (rx_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_idle: rxv=%b rdy=%b busy=%b required 0 1 0", rx_valid, cmd_ready, busy);
    end
    send_cmd(2'd1, 5'd1);
    word_done = 1'b1;
    @(negedge clk);
    word_done = 1'b0;
    n_cmp++;
    if (rx_valid !== 1'b0 || tx_ready !== 1'b0 || cs_low !== 3'b101) begin
      n_bad++;
      $display("FAIL stray_setup: rxv=%b txr=%b cs=%b required 0 0 101", rx_valid, tx_ready, cs_low);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stray_setup_len: txr=%b required 1", tx_ready);
    end
    word_done = 1'b1;
    @(negedge clk);
    word_done = 1'b0;
    n_cmp++;
    if (rx_valid !== 1'b0 || tx_ready !== 1'b1 || spi_en !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_wait_tx: rxv=%b txr=%b en=%b required 0 1 0", rx_valid, tx_ready, spi_en);
    end
    do_word(8'h77, 8'h88, 0);
    wait_idle();
    n_cmp++;
    if (n_rxv - rx0 != 1 || obs_rx !== 8'h88) begin
      n_bad++;
      $display("FAIL stray_count: rx_strobes=%0d rx=%h required 1 88", n_rxv - rx0, obs_rx);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_reject();
    test_reset_mid_burst();
    test_stray_done();
    n_cmp++;
    if (n_multi_cs != 0) begin
      n_bad++;
      $display("FAIL cs_onehot: cycles_with_multiple_cs_low=%0d required 0", n_multi_cs);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
